// File: rtl/mips_pkg.sv
// mips_pkg: fetch-stage state encoding and shared constants
package mips_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} fetch_state_e;
  localparam logic [31:0] NOP_INST = 32'h0;
  localparam int PC_INC = 4;
endpackage

// File: rtl/if_fetch.sv
// if_fetch: PC owner and imem handshake with delay-slot branch redirects (optional PC_ALIGN_CHECK_EN)
module if_fetch
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_branch_flag,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic [ADDR_W-1:0] o_if_pc,
  output logic [INST_W-1:0] o_if_inst,
  output logic              o_stall_req,
  output logic              o_if_misalign
);
  fetch_state_e state;
  logic [ADDR_W-1:0] pc, pend_target, next_pc;
  logic [INST_W-1:0] hold_buf;
  logic hold_valid, pend_valid, fetch, hold, misalign, ack, advance;
  assign fetch = !rst && state == FETCH;
  assign hold  = !rst && state == HOLD;
`ifdef PC_ALIGN_CHECK_EN
  assign misalign = fetch && pc[1:0] != 2'b00;
`else
  assign misalign = 1'b0;
`endif
  // a misaligned fetch completes at once, with a NOP in place of the word
  assign ack     = fetch && (i_imem_ack || misalign);
  assign advance = (ack || hold) && !i_stall;
  assign next_pc = i_branch_flag ? i_branch_target
                 : pend_valid    ? pend_target
                 : pc + ADDR_W'(PC_INC);
  assign o_imem_req    = fetch && !misalign;
  assign o_imem_addr   = pc;
  assign o_if_pc       = (fetch || hold) ? pc : '0;
  assign o_if_inst     = (hold && hold_valid) ? hold_buf
                       : (ack && !misalign)   ? i_imem_rdata
                       : INST_W'(NOP_INST);
  assign o_stall_req   = fetch && !ack;
  assign o_if_misalign = misalign;
  // PC, fetch FSM, hold buffer and pending-redirect bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      state       <= IDLE;
      hold_valid  <= 1'b0;
      hold_buf    <= '0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      if (advance) pc <= next_pc;
      pend_valid <= !advance && (i_branch_flag || pend_valid);
      if (i_branch_flag) pend_target <= i_branch_target;
      state <= state == IDLE          ? FETCH
             : (ack && i_stall)       ? HOLD
             : (hold && !i_stall)     ? FETCH
             : state;
      if (ack && i_stall) begin
        hold_buf   <= misalign ? INST_W'(NOP_INST) : i_imem_rdata;
        hold_valid <= 1'b1;
      end else if (advance) begin
        hold_valid <= 1'b0;
      end
    end
  end
endmodule
